// File: rtl/fu_alu_pipe_pkg.sv
// rtl/fu_alu_pipe_pkg.sv - RV32I ALU FU types, limits and the shared golden datapath
package fu_alu_pipe_pkg;

  localparam int ALU_LAT_MAX = 4;
  localparam int ALU_Q_MAX   = 8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  fi;
    logic [4:0]  fj;
    logic [4:0]  fk;
    logic [31:0] inst;
    logic [63:0] order;
  } fu_status_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] inst;
    logic [63:0] order;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } fu_complete_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] pc_wdata;
  } alu_out_t;

  function automatic alu_out_t alu_compute(input fu_status_t s);
    alu_out_t    o;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        is_reg;
    logic        is_lui;
    logic        is_auipc;
    logic        is_link;
    is_reg   = (s.opcode == OPC_OP);
    is_lui   = (s.opcode == OPC_LUI);
    is_auipc = (s.opcode == OPC_AUIPC);
    is_link  = (s.opcode == OPC_JAL) || (s.opcode == OPC_JALR);
    a  = (is_auipc || is_link) ? s.pc : (is_lui ? 32'd0 : s.vj);
    b  = is_link ? 32'd4 : (is_reg ? s.vk : s.imm);
    sh = b[4:0];
    o.result = '0;
    if (is_lui || is_auipc || is_link) begin
      o.result = a + b;
    end else begin
      case (s.funct3)
        F3_ADD:  o.result = (is_reg && s.funct7[5]) ? a - b : a + b;
        F3_SLL:  o.result = a << sh;
        F3_SLT:  o.result = {31'd0, $signed(a) < $signed(b)};
        F3_SLTU: o.result = {31'd0, a < b};
        F3_XOR:  o.result = a ^ b;
        F3_SR:   o.result = s.funct7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
        F3_OR:   o.result = a | b;
        F3_AND:  o.result = a & b;
        default: o.result = '0;
      endcase
    end
    if (s.opcode == OPC_JAL)       o.pc_wdata = s.pc + s.imm;
    else if (s.opcode == OPC_JALR) o.pc_wdata = (s.vj + s.imm) & ~32'd1;
    else                           o.pc_wdata = s.pc + 32'd4;
    return o;
  endfunction

endpackage

// File: rtl/fu_alu_pipe_if.sv
// rtl/fu_alu_pipe_if.sv - issue and completion handshake bundle for the pipelined ALU FU
interface fu_alu_pipe_if;
  import fu_alu_pipe_pkg::*;

  logic         issue_valid;
  logic         issue_ready;
  fu_status_t   issue_data;
  logic         complete_valid;
  logic         complete_ready;
  fu_complete_t complete_data;

  modport master (
    output issue_valid, issue_data, complete_ready,
    input  issue_ready, complete_valid, complete_data
  );

  modport slave (
    input  issue_valid, issue_data, complete_ready,
    output issue_ready, complete_valid, complete_data
  );

endinterface

// File: rtl/fu_result_queue.sv
// rtl/fu_result_queue.sv - circular FIFO holding completed ALU results until the CDB takes them
module fu_result_queue #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Full push+pop overwrites the slot being read this cycle; head_o already shows the old entry.
  always_ff @(posedge clk) begin
    if (push_i && !rst && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fu_alu_pipe.sv
// rtl/fu_alu_pipe.sv - LATENCY-stage RV32I ALU functional unit with credited result queue
module fu_alu_pipe
  import fu_alu_pipe_pkg::*;
#(
  parameter int  LATENCY   = 1,
  parameter int  OUT_DEPTH = 2,
  localparam int CAP       = LATENCY + OUT_DEPTH,
  localparam int OW        = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fu_alu_pipe_if.slave  bus,
  output logic          exec_busy,
  output logic [OW-1:0] occupancy
);

  localparam int CW = $clog2(OUT_DEPTH + 1);

  alu_out_t           alu;
  fu_complete_t       issue_c;
  fu_complete_t       d_q [LATENCY];
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] s_rdy;
  fu_complete_t       q_head;
  logic [CW-1:0]      q_count;
  logic               q_full;
  logic               q_empty;
  logic               accept;
  logic               pop;
  logic               q_pop;
  logic               q_push;
  logic               direct;
  logic               last_out;

  always_comb begin
    alu                = alu_compute(bus.issue_data);
    issue_c            = '0;
    issue_c.rd         = bus.issue_data.fi;
    issue_c.result     = alu.result;
    issue_c.pc_rdata   = bus.issue_data.pc;
    issue_c.pc_wdata   = alu.pc_wdata;
    issue_c.rs1_addr   = bus.issue_data.fj;
    issue_c.rs2_addr   = bus.issue_data.fk;
    issue_c.rs1_rdata  = bus.issue_data.vj;
    issue_c.rs2_rdata  = bus.issue_data.vk;
    issue_c.inst       = bus.issue_data.inst;
    issue_c.order      = bus.issue_data.order;
  end

  // With the queue empty the last stage is the head, so an op is visible LATENCY cycles after issue.
  assign bus.complete_valid = v_q[LATENCY-1] || !q_empty;
  assign pop      = bus.complete_valid && bus.complete_ready;
  assign q_pop    = pop && !q_empty;
  assign direct   = pop && q_empty;
  assign q_push   = v_q[LATENCY-1] && !direct && (!q_full || q_pop);
  assign last_out = direct || q_push;

  always_comb begin
    bus.complete_data = '0;
    if (!q_empty)            bus.complete_data = q_head;
    else if (v_q[LATENCY-1]) bus.complete_data = d_q[LATENCY-1];
  end

  // Stage i may load when it is empty or its content moves on; bubbles collapse under backpressure.
  always_comb begin
    logic r;
    s_rdy = '0;
    r = !v_q[LATENCY-1] || last_out;
    s_rdy[LATENCY-1] = r;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      r = !v_q[i] || r;
      s_rdy[i] = r;
    end
  end

  always_comb begin
    occupancy = OW'(q_count);
    for (int i = 0; i < LATENCY; i++) occupancy = occupancy + OW'(v_q[i]);
  end

  assign bus.issue_ready = (occupancy < OW'(CAP)) || pop;
  assign accept          = bus.issue_valid && bus.issue_ready && !flush;
  assign exec_busy       = (occupancy != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= '0;
    end else begin
      if (s_rdy[0]) v_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        if (s_rdy[i]) v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_rdy[0] && accept) d_q[0] <= issue_c;
    for (int i = 1; i < LATENCY; i++) begin
      if (s_rdy[i] && v_q[i-1]) d_q[i] <= d_q[i-1];
    end
  end

  fu_result_queue #(
    .T     (fu_complete_t),
    .DEPTH (OUT_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (q_push),
    .data_i  (d_q[LATENCY-1]),
    .pop_i   (q_pop),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb/tb_fu_alu_pipe.sv - scoreboard bench for fu_alu_pipe at LATENCY 1, 2 and 3
module tb_fu_alu_pipe;
  import fu_alu_pipe_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pcw;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0]       iv = '0;
  logic [2:0]       cr = '1;
  logic [2:0]       fl = '0;
  fu_status_t       idata [3];
  logic [2:0]       ir;
  logic [2:0]       cv;
  logic [2:0]       busy;
  logic [2:0]       cd_nz;
  logic [2:0][2:0]  occ_a;
  logic [2:0][31:0] hres;
  exp_t             expq [3][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int OW = $clog2(g + 4);
    fu_alu_pipe_if bus ();
    logic          busy_w;
    logic [OW-1:0] occ_w;
    exp_t          e;

    assign bus.issue_valid    = iv[g];
    assign bus.issue_data     = idata[g];
    assign bus.complete_ready = cr[g];
    assign ir[g]    = bus.issue_ready;
    assign cv[g]    = bus.complete_valid;
    assign busy[g]  = busy_w;
    assign occ_a[g] = 3'(occ_w);
    assign cd_nz[g] = |bus.complete_data;
    assign hres[g]  = bus.complete_data.result;

    fu_alu_pipe #(.LATENCY(g + 1), .OUT_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl[g]),
      .bus       (bus),
      .exec_busy (busy_w),
      .occupancy (occ_w)
    );

    always @(negedge clk) begin
      if (!rst && bus.complete_valid && bus.complete_ready) begin
        if (expq[g].size() == 0) begin
          n_total++;
          $display("FAIL u%0d unexpected_output: got result 0x%08h, required no output", g,
                   bus.complete_data.result);
        end else begin
          e = expq[g].pop_front();
          chk($sformatf("u%0d result", g), bus.complete_data.result, e.res);
          chk($sformatf("u%0d pc_wdata", g), bus.complete_data.pc_wdata, e.pcw);
          chk($sformatf("u%0d rd", g), 32'(bus.complete_data.rd), 32'(e.rd));
          if (e.cyc >= 0) chk($sformatf("u%0d complete_cycle", g), 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  function automatic fu_status_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] vj,
                                    input logic [31:0] vk, input logic [31:0] imm,
                                    input logic [31:0] pc, input logic [4:0] fi);
    fu_status_t s;
    s        = '0;
    s.opcode = opc;
    s.funct3 = f3;
    s.funct7 = f7;
    s.vj     = vj;
    s.vk     = vk;
    s.imm    = imm;
    s.pc     = pc;
    s.fi     = fi;
    s.fj     = fi + 5'd1;
    s.fk     = fi + 5'd2;
    s.inst   = 32'h0000_0013;
    s.order  = 64'(fi);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input fu_status_t s, input logic [31:0] res,
                          input logic [31:0] pcw, input int lat);
    exp_t e;
    e.res = res;
    e.pcw = pcw;
    e.rd  = s.fi;
    e.cyc = (lat > 0) ? cyc + lat : -1;
    expq[k].push_back(e);
  endtask

  // Leaves issue_valid high so consecutive calls issue back-to-back.
  task automatic drive(input int k, input fu_status_t s, input logic [31:0] res,
                       input logic [31:0] pcw, input int lat);
    int w;
    iv[k]    = 1'b1;
    idata[k] = s;
    push_exp(k, s, res, pcw, lat);
    w = 0;
    @(negedge clk);
    while (!ir[k] && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!ir[k]) begin
      n_total++;
      $display("FAIL u%0d issue_timeout: issue_ready 0, required 1", k);
    end
    tick();
  endtask

  initial begin
    int w;
    for (int k = 0; k < 3; k++) idata[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d reset issue_ready", k), 32'(ir[k]), 32'd1);
      chk($sformatf("u%0d reset complete_valid", k), 32'(cv[k]), 32'd0);
      chk($sformatf("u%0d reset exec_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("u%0d reset occupancy", k), 32'(occ_a[k]), 32'd0);
      chk($sformatf("u%0d reset complete_data_nonzero", k), 32'(cd_nz[k]), 32'd0);
    end
    tick();

    // LATENCY=1: basic ops and link / compare / shift corners
    drive(0, mk(OPC_OP,     3'b000, 7'h00, 32'd5,        32'd7,  32'd0,        32'h100,  5'd3), 32'd12,        32'h104,  1);
    drive(0, mk(OPC_JALR,   3'b000, 7'h00, 32'h1001,     32'd0,  32'd2,        32'h40,   5'd4), 32'h44,        32'h1002, 1);
    drive(0, mk(OPC_OP_IMM, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd0,  32'd0,        32'h50,   5'd5), 32'd1,         32'h54,   1);
    drive(0, mk(OPC_OP_IMM, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd0,  32'd0,        32'h54,   5'd6), 32'd0,         32'h58,   1);
    drive(0, mk(OPC_OP,     3'b001, 7'h00, 32'd3,        32'd33, 32'd0,        32'h58,   5'd7), 32'd6,         32'h5C,   1);
    drive(0, mk(OPC_AUIPC,  3'b111, 7'h00, 32'd9,        32'd0,  32'h2000,     32'h1000, 5'd8), 32'h3000,      32'h1004, 1);
    drive(0, mk(OPC_JAL,    3'b000, 7'h00, 32'd0,        32'd0,  32'h10,       32'h200,  5'd9), 32'h204,       32'h210,  1);
    drive(0, mk(OPC_OP,     3'b101, 7'h00, 32'h80000000, 32'd4,  32'd0,        32'h60,   5'd10), 32'h08000000, 32'h64,   1);
    iv[0] = 1'b0;

    // LATENCY=3: back-to-back SUB, SRAI, LUI
    drive(2, mk(OPC_OP,     3'b000, 7'h20, 32'd3,        32'd5,  32'd0,        32'h10,   5'd1), 32'hFFFFFFFE,  32'h14,   3);
    drive(2, mk(OPC_OP_IMM, 3'b101, 7'h20, 32'h80000000, 32'd0,  32'd4,        32'h14,   5'd2), 32'hF8000000,  32'h18,   3);
    drive(2, mk(OPC_LUI,    3'b000, 7'h00, 32'hDEAD,     32'd0,  32'h12345000, 32'h18,   5'd3), 32'h12345000,  32'h1C,   3);
    iv[2] = 1'b0;

    // LATENCY=2, OUT_DEPTH=2 under backpressure: four held, fifth waits, then pop+accept together
    cr[1] = 1'b0;
    for (int i = 0; i < 4; i++)
      drive(1, mk(OPC_OP_IMM, 3'b000, 7'h00, 32'(i), 32'd0, 32'd100, 32'h300 + 32'(4 * i), 5'(11 + i)),
            32'd100 + 32'(i), 32'h304 + 32'(4 * i), -1);
    iv[1]    = 1'b1;
    idata[1] = mk(OPC_OP_IMM, 3'b000, 7'h00, 32'd4, 32'd0, 32'd100, 32'h310, 5'd15);
    push_exp(1, idata[1], 32'd104, 32'h314, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("u1 full issue_ready", 32'(ir[1]), 32'd0);
      chk("u1 full occupancy", 32'(occ_a[1]), 32'd4);
      chk("u1 full head stable", hres[1], 32'd100);
      chk("u1 full complete_valid", 32'(cv[1]), 32'd1);
      tick();
    end
    cr[1] = 1'b1;
    @(negedge clk);
    chk("u1 issue_ready with pop", 32'(ir[1]), 32'd1);
    tick();
    iv[1] = 1'b0;
    @(negedge clk);
    chk("u1 occupancy after pop+accept", 32'(occ_a[1]), 32'd4);
    tick();
    w = 0;
    while (expq[1].size() != 0 && w < 50) begin
      w++;
      tick();
    end

    // Flush with three held ops and a simultaneous issue: nothing survives
    cr[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[1]    = 1'b1;
      idata[1] = mk(OPC_OP, 3'b000, 7'h00, 32'hBAD0 + 32'(i), 32'd1, 32'd0, 32'h400, 5'(20 + i));
      tick();
    end
    idata[1] = mk(OPC_OP, 3'b000, 7'h00, 32'hBAD9, 32'd1, 32'd0, 32'h400, 5'd23);
    fl[1]    = 1'b1;
    tick();
    fl[1] = 1'b0;
    iv[1] = 1'b0;
    @(negedge clk);
    chk("u1 flush occupancy", 32'(occ_a[1]), 32'd0);
    chk("u1 flush complete_valid", 32'(cv[1]), 32'd0);
    chk("u1 flush exec_busy", 32'(busy[1]), 32'd0);
    chk("u1 flush complete_data_nonzero", 32'(cd_nz[1]), 32'd0);
    tick();
    cr[1] = 1'b1;
    repeat (6) tick();
    drive(1, mk(OPC_OP, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h500, 5'd24), 32'd0, 32'h504, 2);
    iv[1] = 1'b0;

    w = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && w < 100) begin
      w++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (expq[k].size() != 0) begin
        n_total++;
        $display("FAIL u%0d drain_timeout: %0d results outstanding, required 0", k, expq[k].size());
      end
    end
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
